rf_scoreboard: RTL and testbench

- Hazard/issue controller for the 15-entry register file (R0-R14) of the 32-bit ARM pipeline.
- Tracks in-flight write-backs per register with small up/down counters: up on issue, down on write-back.
- Produces the ID-stage stall (hazard) and issue acknowledge.
- Sits beside the register file between the ID stage and the EXE/MEM/WB pipeline registers.

---
 rtl/rf_scoreboard_pkg.sv | 12 +
 rtl/rf_scoreboard_if.sv | 40 ++++
 rtl/rf_scoreboard_sb_counter.sv | 37 +++
 rtl/rf_scoreboard.sv | 69 ++++++
 tb/tb_rf_scoreboard.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and types for the register-file scoreboard.
// R15 is the PC and is never tracked.
package rf_pkg;

  localparam int NUM_REGS = 15;
  localparam int REG_IDX_W = 4;
  localparam int CNT_W = 2;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard_if.sv
// Issue / write-back bundle between the ID stage and the scoreboard.
// The master is the pipeline side, the slave is the scoreboard.
interface rf_scoreboard_if;
  import rf_pkg::*;

  logic issue_valid;
  logic issue_wb_en;
  reg_idx_t issue_dest;
  reg_idx_t issue_src1;
  reg_idx_t issue_src2;
  logic issue_use_src2;
  logic wb_en;
  reg_idx_t wb_dest;
  logic hazard;
  logic issue_ack;
  logic [NUM_REGS-1:0] pending_mask;
  logic err_overflow;
  logic err_underflow;

  modport master (
    output issue_valid, issue_wb_en,
    output issue_dest, issue_src1,
    output issue_src2, issue_use_src2,
    output wb_en, wb_dest,
    input hazard, issue_ack,
    input pending_mask,
    input err_overflow, err_underflow
  );

  modport slave (
    input issue_valid, issue_wb_en,
    input issue_dest, issue_src1,
    input issue_src2, issue_use_src2,
    input wb_en, wb_dest,
    output hazard, issue_ack,
    output pending_mask,
    output err_overflow, err_underflow
  );

endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// Saturating up/down count of in-flight writers for one register.
// Simultaneous inc and dec cancel; error pulses flag the clipped cases.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             ovf_pulse,
  output logic             unf_pulse
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic up;
  logic dn;

  assign up = inc & ~dec;
  assign dn = dec & ~inc;
  assign nonzero = |cnt;
  assign ovf_pulse = up & (cnt == MAX);
  assign unf_pulse = dn & ~nonzero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (up && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end else if (dn && nonzero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// ID-stage hazard/issue controller: per-register pending counters,
// source compare, and sticky counter error flags.
module rf_scoreboard #(
  parameter int NUM_REGS  = rf_pkg::NUM_REGS,
  parameter int CNT_W     = rf_pkg::CNT_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  rf_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] nz;
  logic [NUM_REGS-1:0] ovf;
  logic [NUM_REGS-1:0] unf;
  logic [NUM_REGS-1:0] live;
  logic [15:0]         live_pad;
  logic                pend1;
  logic                pend2;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam rf_pkg::reg_idx_t IDX = rf_pkg::reg_idx_t'(i);

    assign inc[i] = sb.issue_ack & sb.issue_wb_en
                  & (sb.issue_dest == IDX);
    assign dec[i] = sb.wb_en & (sb.wb_dest == IDX);

    // Last writer retiring this cycle is visible via the negedge RF write.
    assign live[i] = nz[i]
                   & ~(WB_BYPASS & dec[i] & (cnt[i] == ONE));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[i]),
      .dec       (dec[i]),
      .cnt       (cnt[i]),
      .nonzero   (nz[i]),
      .ovf_pulse (ovf[i]),
      .unf_pulse (unf[i])
    );
  end

  // Index 15 lands on a zero pad bit, so the PC is never pending.
  assign live_pad = 16'(live);
  assign pend1 = live_pad[sb.issue_src1];
  assign pend2 = live_pad[sb.issue_src2];

  assign sb.hazard = sb.issue_valid
                   & (pend1 | (sb.issue_use_src2 & pend2));
  assign sb.issue_ack = sb.issue_valid & ~sb.hazard;
  assign sb.pending_mask = nz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.err_overflow  <= 1'b0;
      sb.err_underflow <= 1'b0;
    end else begin
      sb.err_overflow  <= sb.err_overflow | (|ovf);
      sb.err_underflow <= sb.err_underflow | (|unf);
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed table, reset sequence, random run.
// Two instances cover WB_BYPASS=1 (index 0) and WB_BYPASS=0 (index 1).
module tb_rf_scoreboard;

  typedef struct {
    logic iv, iwb;
    logic [3:0] dest, s1, s2;
    logic u2, wb;
    logic [3:0] wd;
    logic h0, h1;
    logic [14:0] mask;
    logic [1:0] err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  int mc [2][15];
  bit mo [2];
  bit mu [2];

  rf_scoreboard_if ifb0 ();
  rf_scoreboard_if ifb1 ();

  assign ifb1.issue_valid    = ifb0.issue_valid;
  assign ifb1.issue_wb_en    = ifb0.issue_wb_en;
  assign ifb1.issue_dest     = ifb0.issue_dest;
  assign ifb1.issue_src1     = ifb0.issue_src1;
  assign ifb1.issue_src2     = ifb0.issue_src2;
  assign ifb1.issue_use_src2 = ifb0.issue_use_src2;
  assign ifb1.wb_en          = ifb0.wb_en;
  assign ifb1.wb_dest        = ifb0.wb_dest;

  rf_scoreboard #(.WB_BYPASS(1'b1)) dut0 (
    .clk (clk), .rst (rst), .sb (ifb0.slave)
  );
  rf_scoreboard #(.WB_BYPASS(1'b0)) dut1 (
    .clk (clk), .rst (rst), .sb (ifb1.slave)
  );

  always #5 clk = ~clk;

  logic        d_haz [2];
  logic        d_ack [2];
  logic [14:0] d_msk [2];
  logic [1:0]  d_err [2];

  assign d_haz[0] = ifb0.hazard;
  assign d_haz[1] = ifb1.hazard;
  assign d_ack[0] = ifb0.issue_ack;
  assign d_ack[1] = ifb1.issue_ack;
  assign d_msk[0] = ifb0.pending_mask;
  assign d_msk[1] = ifb1.pending_mask;
  assign d_err[0] = {ifb0.err_overflow, ifb0.err_underflow};
  assign d_err[1] = {ifb1.err_overflow, ifb1.err_underflow};

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic bit mpend(int b, logic [3:0] s,
                               logic wb, logic [3:0] wd);
    if (s == 4'd15) return 1'b0;
    if (mc[b][s] == 0) return 1'b0;
    if (b == 0 && wb && wd == s && mc[b][s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [14:0] mmask(int b);
    logic [14:0] m = '0;
    for (int i = 0; i < 15; i++) m[i] = (mc[b][i] != 0);
    return m;
  endfunction

  task automatic mclear();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 15; i++) mc[b][i] = 0;
      mo[b] = 0;
      mu[b] = 0;
    end
  endtask

  task automatic drive(vec_t v);
    ifb0.issue_valid    = v.iv;
    ifb0.issue_wb_en    = v.iwb;
    ifb0.issue_dest     = v.dest;
    ifb0.issue_src1     = v.s1;
    ifb0.issue_src2     = v.s2;
    ifb0.issue_use_src2 = v.u2;
    ifb0.wb_en          = v.wb;
    ifb0.wb_dest        = v.wd;
  endtask

  task automatic check_model();
    bit eh;
    for (int b = 0; b < 2; b++) begin
      eh = ifb0.issue_valid && (
             mpend(b, ifb0.issue_src1, ifb0.wb_en, ifb0.wb_dest) ||
             (ifb0.issue_use_src2 &&
              mpend(b, ifb0.issue_src2, ifb0.wb_en, ifb0.wb_dest)));
      chk($sformatf("hazard[%0d]", b), d_haz[b], eh);
      chk($sformatf("ack[%0d]", b), d_ack[b],
          ifb0.issue_valid && !eh);
      chk($sformatf("mask[%0d]", b), d_msk[b], mmask(b));
      chk($sformatf("err[%0d]", b), d_err[b], {mo[b], mu[b]});
    end
  endtask

  // Model update from the counting rules, done per instance.
  task automatic model_step(bit h0, bit h1);
    int di, dq;
    bit hz;
    for (int b = 0; b < 2; b++) begin
      hz = (b == 0) ? h0 : h1;
      di = -1;
      dq = -1;
      if (ifb0.issue_valid && !hz && ifb0.issue_wb_en &&
          ifb0.issue_dest != 4'd15) di = ifb0.issue_dest;
      if (ifb0.wb_en && ifb0.wb_dest != 4'd15) dq = ifb0.wb_dest;
      if (di >= 0 && di == dq) continue;
      if (di >= 0) begin
        if (mc[b][di] == 3) mo[b] = 1;
        else mc[b][di]++;
      end
      if (dq >= 0) begin
        if (mc[b][dq] == 0) mu[b] = 1;
        else mc[b][dq]--;
      end
    end
  endtask

  task automatic apply(vec_t v, bit tab, string n);
    bit h0, h1;
    drive(v);
    #1;
    check_model();
    h0 = d_haz[0];
    h1 = d_haz[1];
    if (tab) begin
      chk({n, ".h0"}, d_haz[0], v.h0);
      chk({n, ".ack0"}, d_ack[0], v.iv & ~v.h0);
      chk({n, ".h1"}, d_haz[1], v.h1);
    end
    @(posedge clk);
    model_step(h0, h1);
    #1;
    if (tab) begin
      chk({n, ".mask"}, d_msk[0], v.mask);
      chk({n, ".err"}, d_err[0], v.err);
    end
  endtask

  vec_t tbl [18];
  vec_t idle;
  vec_t v;

  initial begin
    // iv iwb dest s1 s2 u2 wb wd | h0 h1 mask_after err_after
    tbl[0]  = '{1,1,3,1,2,1,0,0,    0,0,15'h0008,2'b00};
    tbl[1]  = '{1,1,4,3,0,0,0,0,    1,1,15'h0008,2'b00};
    tbl[2]  = '{1,1,4,3,0,0,1,3,    0,1,15'h0010,2'b00};
    tbl[3]  = '{1,1,5,0,0,0,0,0,    0,0,15'h0030,2'b00};
    tbl[4]  = '{1,1,5,0,0,0,1,5,    0,0,15'h0030,2'b00};
    tbl[5]  = '{1,1,7,0,0,0,0,0,    0,0,15'h00B0,2'b00};
    tbl[6]  = '{1,1,7,0,0,0,0,0,    0,0,15'h00B0,2'b00};
    tbl[7]  = '{1,1,7,0,0,0,0,0,    0,0,15'h00B0,2'b00};
    tbl[8]  = '{1,1,7,0,0,0,0,0,    0,0,15'h00B0,2'b10};
    tbl[9]  = '{0,0,0,0,0,0,1,7,    0,0,15'h00B0,2'b10};
    tbl[10] = '{0,0,0,0,0,0,1,7,    0,0,15'h00B0,2'b10};
    tbl[11] = '{0,0,0,0,0,0,1,7,    0,0,15'h0030,2'b10};
    tbl[12] = '{0,0,0,0,0,0,1,9,    0,0,15'h0030,2'b11};
    tbl[13] = '{1,0,0,15,15,1,0,0,  0,0,15'h0030,2'b11};
    tbl[14] = '{0,0,0,0,0,0,1,15,   0,0,15'h0030,2'b11};
    tbl[15] = '{1,1,15,4,0,0,0,0,   1,0,15'h0030,2'b11};
    tbl[16] = '{1,0,0,0,5,1,0,0,    1,1,15'h0030,2'b11};
    tbl[17] = '{1,0,0,0,5,0,0,0,    0,0,15'h0030,2'b11};
    idle = '{0,0,0,0,0,0,0,0,0,0,15'h0,2'b00};

    rst = 1'b1;
    drive(idle);
    mclear();
    #3;
    check_model();
    #9;
    rst = 1'b0;

    for (int i = 0; i < 18; i++)
      apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Fill R2 and R6, then pull reset in the middle of a cycle.
    v = idle;
    v.iv = 1; v.iwb = 1; v.dest = 2;
    apply(v, 1'b0, "");
    v.dest = 6;
    apply(v, 1'b0, "");
    drive(idle);
    chk("pre_rst_mask", d_msk[0], 15'h0074);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mask", d_msk[0], 0);
    chk("arst_err", d_err[0], 0);
    mclear();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    v = idle;
    v.iv = 1; v.s1 = 2;
    drive(v);
    #1;
    chk("post_rst_haz", d_haz[0], 0);
    apply(v, 1'b0, "");

    for (int n = 0; n < 800; n++) begin
      v.iv   = ($urandom_range(0, 3) != 0);
      v.iwb  = ($urandom_range(0, 3) != 0);
      v.dest = 4'($urandom_range(0, 15));
      v.s1   = 4'($urandom_range(0, 15));
      v.s2   = 4'($urandom_range(0, 15));
      v.u2   = 1'($urandom_range(0, 1));
      v.wb   = 1'($urandom_range(0, 1));
      v.wd   = 4'($urandom_range(0, 15));
      apply(v, 1'b0, "");
      if (n % 200 == 199) begin
        rst = 1'b1;
        #1;
        mclear();
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
